agu_queue: RTL
==============

// Module: agu_queue
// PURPOSE
//  Parametrised address generation unit with an output queue. Computes load/store
//  effective address base+offset, flags misalignment and buffers results with the op,
//  ROB tag and store data. Sits between the RS/issue stage and the load/store buffer.
//  Adds valid/ready flow control and pipeline flush.
// PARAMETERS
//  XLEN    32        data/address width
//  OP_W    5         memory op code width
//  TAG_W   3         ROB tag width
//  DEPTH   4         queue entries; power of two, >= 2
//  OP_NOP  5'b11111  op value driven when queue empty
// PORTS
//  clk            in   1       clock, all logic on posedge
//  rst            in   1       synchronous reset, active-low
//  flush          in   1       mispredict flush; discard all entries
//  in_valid       in   1       request present
//  in_ready       out  1       queue can accept
//  in_base        in   XLEN    base operand (rs1)
//  in_offset      in   XLEN    offset operand (sign-extended imm)
//  in_op          in   OP_W    memory op; op[1:0] size, op[3] store
//  in_tag         in   TAG_W   ROB tag
//  in_store_data  in   XLEN    store value (don't-care for loads)
//  out_valid      out  1       head entry valid
//  out_ready      in   1       consumer takes head
//  out_addr       out  XLEN    effective address of head
//  out_op         out  OP_W    op of head; OP_NOP when empty
//  out_tag        out  TAG_W   tag of head; 0 when empty
//  out_store_data out  XLEN    store value of head
//  out_misalign   out  1       head address misaligned for its size
//  count          out  $clog2(DEPTH)+1  occupancy
// BEHAVIOUR
//  - Reset (rst==0 at posedge): pointers/count 0, all entries invalid; outputs then
//    out_valid=0, out_op=OP_NOP, out_tag=0, out_addr=0, out_store_data=0,
//    out_misalign=0, in_ready=1. Reset dominates flush and handshakes.
//  - Accept when in_valid&&in_ready; addr = in_base+in_offset mod 2^XLEN (carry dropped),
//    computed and written into tail entry in the accepting cycle.
//  - Latency: accepted request is at head (out_valid=1) on the following cycle if the
//    queue was empty; no combinational path from in_* to out_*.
//  - Pop when out_valid&&out_ready; head advances next cycle.
//  - in_ready = (count != DEPTH); no enqueue-on-pop bypass when full.
//  - Simultaneous push and pop: count unchanged, both pointers advance.
//  - Pointers wrap modulo DEPTH; count distinguishes full vs empty.
//  - Outputs are driven from head entry registers; when empty out_op=OP_NOP,
//    out_tag=0, out_misalign=0, out_addr/out_store_data hold 0.
//  - Misalign: size 00 byte never; 01 half if addr[0]; 10 word if addr[1:0]!=0;
//    11 reserved, treated as word. Computed at enqueue, stored per entry.
//  - Flush: at posedge with flush=1, all entries dropped, count=0; a push or pop
//    in the same cycle is discarded. in_ready=1 from next cycle.
//  - Tag and store data pass through unmodified; no reordering (strict FIFO).
// STRUCTURE
//  - agu_pkg: size codes (SZ_B/SZ_H/SZ_W), STORE_BIT index, OP_NOP default,
//    function misaligned(addr[1:0], size).
//  - One sub-module: agu_fifo (generic DEPTH x WIDTH storage, ptrs, count, flush);
//    agu_queue holds adder, misalign logic, packs entry {addr,op,tag,data,misalign}.
// TESTING
//  1 Reset: rst=0 two cycles -> out_valid=0, out_op=5'h1F, out_tag=0, in_ready=1, count=0.
//  2 Single load: base=0x1000, off=0x4, op=LW(size 10), tag=3, out_ready=0 -> next cycle
//    out_valid=1, out_addr=0x1004, out_tag=3, out_misalign=0; holds until out_ready=1.
//  3 Fill: 4 pushes with out_ready=0 -> count=4, in_ready=0; 5th in_valid ignored;
//    then drain in order, tags 0,1,2,3; push+pop same cycle keeps count.
//  4 Misalign/wrap: base=0xFFFFFFFF, off=0x3, size 01 -> addr=0x2, misalign=0;
//    base=0x1001, off=0, size 10 -> misalign=1; size 00 -> misalign=0.
//  5 Flush: 3 entries queued, flush=1 with concurrent push -> next cycle count=0,
//    out_valid=0, out_op=OP_NOP; pushed entry not present.
//  6 Reset mid-operation: queue 2 entries, rst=0 with push+pop active -> all cleared.

Source files
------------

// File: rtl/agu_pkg.sv
// Shared definitions for the address generation unit: access size codes,
// op field layout, the idle op value and the misalignment rule.
package agu_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    localparam int STORE_BIT = 3;

    localparam logic [4:0] AGU_OP_NOP = 5'b11111;

    // Size code 2'b11 is reserved and checked like a word access.
    function automatic logic misaligned(
        input logic [1:0] addr_lo,
        input logic [1:0] size
    );
        logic m;
        case (size)
            SZ_B:    m = 1'b0;
            SZ_H:    m = addr_lo[0];
            SZ_W:    m = (addr_lo != 2'b00);
            default: m = (addr_lo != 2'b00);
        endcase
        return m;
    endfunction

    function automatic logic is_store(input logic [4:0] op);
        return op[STORE_BIT];
    endfunction

endpackage

// File: rtl/agu_fifo.sv
// Generic DEPTH x WIDTH FIFO with occupancy count and flush.
// Ports: clk, rst (sync, active-low), flush, push_i/wdata_i, pop_i,
// rdata_o (head entry), full_o, empty_o, count_o.
module agu_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CW-1:0]    count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;

    logic do_push;
    logic do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // No enqueue-on-pop bypass: a full queue refuses pushes even
    // when the head is leaving in the same cycle.
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // DEPTH is a power of two, so pointer overflow is the wrap.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: an entry is only visible once counted.
    always_ff @(posedge clk) begin
        if (rst && !flush && do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/agu_queue.sv
// Load/store address generation with a result queue toward the LSU.
// Ports: clk, rst (sync, active-low), flush; in_* request with valid/ready;
// out_* head entry with valid/ready; count = occupancy.
module agu_queue
    import agu_pkg::*;
#(
    parameter  int             XLEN   = 32,
    parameter  int             OP_W   = 5,
    parameter  int             TAG_W  = 3,
    parameter  int             DEPTH  = 4,
    parameter  logic [OP_W-1:0] OP_NOP = OP_W'(AGU_OP_NOP),
    localparam int             CW     = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  in_base,
    input  logic [XLEN-1:0]  in_offset,
    input  logic [OP_W-1:0]  in_op,
    input  logic [TAG_W-1:0] in_tag,
    input  logic [XLEN-1:0]  in_store_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_addr,
    output logic [OP_W-1:0]  out_op,
    output logic [TAG_W-1:0] out_tag,
    output logic [XLEN-1:0]  out_store_data,
    output logic             out_misalign,
    output logic [CW-1:0]    count
);

    localparam int EW = 2 * XLEN + OP_W + TAG_W + 1;

    logic [XLEN-1:0]  ea;
    logic             ea_mis;
    logic [EW-1:0]    wdata;
    logic [EW-1:0]    rdata;
    logic             full;
    logic             empty;
    logic             accept;
    logic             take;

    logic [XLEN-1:0]  h_addr;
    logic [OP_W-1:0]  h_op;
    logic [TAG_W-1:0] h_tag;
    logic [XLEN-1:0]  h_data;
    logic             h_mis;

    // Address wraps modulo 2^XLEN; the carry is simply dropped.
    assign ea     = in_base + in_offset;
    assign ea_mis = misaligned(ea[1:0], in_op[1:0]);
    assign wdata  = {ea, in_op, in_tag, in_store_data, ea_mis};

    assign in_ready  = !full;
    assign out_valid = !empty;
    assign accept    = in_valid && in_ready;
    assign take      = out_valid && out_ready;

    agu_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush   (flush),
        .push_i  (accept),
        .wdata_i (wdata),
        .pop_i   (take),
        .rdata_o (rdata),
        .full_o  (full),
        .empty_o (empty),
        .count_o (count)
    );

    assign {h_addr, h_op, h_tag, h_data, h_mis} = rdata;

    // Stale storage is masked so an empty queue presents idle values.
    assign out_addr       = out_valid ? h_addr : '0;
    assign out_op         = out_valid ? h_op   : OP_NOP;
    assign out_tag        = out_valid ? h_tag  : '0;
    assign out_store_data = out_valid ? h_data : '0;
    assign out_misalign   = out_valid ? h_mis  : 1'b0;

endmodule
